// File: rtl/speed_select_ctrl_pkg.sv
// Shared types and constants for the speed select control stage.
package speed_select_ctrl_pkg;

    typedef enum logic [1:0] {
        DB_RELEASED     = 2'b00,
        DB_PRESS_WAIT   = 2'b01,
        DB_PRESSED      = 2'b10,
        DB_RELEASE_WAIT = 2'b11
    } db_state_e;

    localparam logic [1:0] SPEED_FASTEST = 2'b00;
    localparam logic [1:0] SPEED_SLOWEST = 2'b11;
    localparam logic [1:0] SPEED_RESET   = 2'b01;
    localparam logic       RUN_RESET     = 1'b1;

    // Opposing requests in the same cycle cancel; both ends saturate.
    function automatic logic [1:0] next_speed(input logic [1:0] cur,
                                              input logic       up,
                                              input logic       down);
        logic [1:0] nxt;
        nxt = cur;
        if (up && !down && (cur != SPEED_FASTEST)) begin
            nxt = cur - 2'd1;
        end else if (down && !up && (cur != SPEED_SLOWEST)) begin
            nxt = cur + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/speed_select_ctrl_key_debounce.sv
// Two-flop synchroniser plus debounce FSM for one active-low push button.
module key_debounce
    import speed_select_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic press,
    output logic pressed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= DB_RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            DB_RELEASED: begin
                if (!sync2_q) begin
                    state_d = DB_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            DB_PRESS_WAIT: begin
                if (sync2_q) begin
                    state_d = DB_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DB_PRESSED: begin
                if (sync2_q) begin
                    state_d = DB_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            DB_RELEASE_WAIT: begin
                if (!sync2_q) begin
                    state_d = DB_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign press   = press_q;
    assign pressed = (state_q == DB_PRESSED) || (state_q == DB_RELEASE_WAIT);

endmodule

// File: rtl/speed_select_ctrl.sv
// Button-driven speed select and run flag feeding the clock-rate divider.
module speed_select_ctrl
    import speed_select_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       key_up_n,
    input  logic       key_down_n,
    input  logic       key_pause_n,
    output logic [1:0] speeds,
    output logic       run,
    output logic       speed_changed
);

    logic       up_press, down_press, pause_press;
    logic [2:0] unused_held;

    logic [1:0] speeds_q, speeds_d;
    logic       run_q, run_d;
    logic       changed_q, changed_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (key_up_n),
        .press   (up_press),
        .pressed (unused_held[0])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (key_down_n),
        .press   (down_press),
        .pressed (unused_held[1])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (key_pause_n),
        .press   (pause_press),
        .pressed (unused_held[2])
    );

    always_comb begin
        speeds_d  = next_speed(speeds_q, up_press, down_press);
        run_d     = run_q ^ pause_press;
        changed_d = (speeds_d != speeds_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            speeds_q  <= SPEED_RESET;
            run_q     <= RUN_RESET;
            changed_q <= 1'b0;
        end else begin
            speeds_q  <= speeds_d;
            run_q     <= run_d;
            changed_q <= changed_d;
        end
    end

    assign speeds        = speeds_q;
    assign run           = run_q;
    assign speed_changed = changed_q;

endmodule
